da_dct_engine: RTL and testbench
================================

# da_dct_engine

Parametrised, bit-serial distributed-arithmetic (DA) inner-product engine that computes one 8-point DCT coefficient per input block. It sits between the EEG sample framer and the RLE encoder, and it reads two external 16-entry coefficient ROMs. It adds to the fixed 8-bit DCT stage:

- parametrised sample and ROM widths;
- exact two's-complement sign-bit handling;
- valid/ready handshakes on input and output;
- an internal bit counter in place of a divided clock.

## Interface

Parameters:
- W, 8, signed sample width in bits (≥2); this is also the number of serial cycles per block.
- ROM_W, 16, signed ROM word width.
- OUT_W, ROM_W+W+1, result width; it must not be overridden smaller.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- x_in  in  8*W  packed samples; x_k = x_in[k*W +: W], signed.
- in_valid  in  1  x_in is valid.
- in_ready  out  1  block accepts x_in this cycle.
- addr_a  out  4  ROM A address {x3[b],x2[b],x1[b],x0[b]}.
- addr_b  out  4  ROM B address {x7[b],x6[b],x5[b],x4[b]}.
- rom_a_data  in  ROM_W  signed ROM A word; combinational read of addr_a in the same cycle.
- rom_b_data  in  ROM_W  signed ROM B word; combinational read of addr_b in the same cycle.
- out_data  out  OUT_W  signed result; held stable while out_valid=1.
- out_valid  out  1  result available.
- out_ready  in  1  downstream consumes the result.

## Operation

- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: bit counter b = 0..W-1.
  - HOLD: out_valid=1.
- Accept: an in_valid && in_ready edge latches all eight samples into a shift register and sets b=0. IDLE → RUN.
- RUN, cycle with counter b:
  - addr_a and addr_b are formed from bit b of the latched samples.
  - S_b = rom_a_data + rom_b_data, sign-extended to ROM_W+1 bits.
- Required result: Y = Σ_{b=0}^{W-2} S_b·2^b − S_{W-1}·2^{W-1}.
  - The MSB slice is subtracted; this is two's-complement exact and has no rounding.
  - |Y| < 2^(ROM_W+W), so OUT_W never overflows.
  - Any right-shift/add accumulator structure is acceptable as long as the result is bit-exact.
- When b=W-1 completes: out_data ← Y, state → HOLD, out_valid=1.
- HOLD:
  - in_ready = out_ready.
  - out_ready=1 with in_valid=1: the result is consumed and the new block is accepted in the same edge. HOLD → RUN.
  - out_ready=1 with in_valid=0: HOLD → IDLE, out_valid=0.
  - out_ready=0: hold out_data and out_valid; in_ready=0.
- in_valid is ignored in RUN (in_ready=0); the samples are not re-sampled mid-block.
- addr_a and addr_b are 0 outside RUN.
- The accumulator is cleared at each accept; no state carries between blocks.

## Timing

- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE, b=0, accumulator=0, sample register=0.
  - out_data=0, out_valid=0, addr_a=0, addr_b=0, in_ready=1.
  - Any in-flight block is discarded and no partial result is emitted.
- in_ready is combinational from state and out_ready. out_valid and out_data are registered.
- Latency: accept at edge T → out_valid high after edge T+W.
- Throughput with out_ready held 1 and in_valid held 1: one result every W+1 cycles (W RUN cycles + 1 HOLD cycle).
- ROM timing: address is driven in a cycle, data is used in that same cycle, and there is no ROM pipeline stage.
- Simultaneous out handshake and in accept in HOLD: out_valid drops for exactly the W RUN cycles, then rises with the new result.

## Test plan

Unless stated, the bench uses W=8, ROM_W=16, and ROM_A[a] = ROM_B[a] = popcount(a), so that Y = Σx_k.

- Reset/basic:
  - Stimulus: reset, then all x_k=1 with one-cycle in_valid, out_ready=1.
  - Required response: after reset out_valid=0, out_data=0, in_ready=1; out_data=8 with out_valid high exactly 8 cycles after the accept edge, for one cycle; then IDLE.
- Sign extremes:
  - Stimulus (a): all x_k=-128.
  - Required response (a): out_data=-1024.
  - Stimulus (b): x = {127,-128,5,-7,0,1,-1,64}.
  - Required response (b): out_data=61.
- Weighted ROM:
  - Stimulus: ROM_A[a] = 1000·a0 − 2000·a1, ROM_B = 0, x0=-3, x1=5, others 0.
  - Required response: out_data=-13000.
- Back-pressure:
  - Stimulus: out_ready=0 for 5 cycles after out_valid, in_valid held high.
  - Required response: out_data stable, in_ready=0 throughout; release out_ready → next block accepted on the same edge; second result correct.
- Back-to-back:
  - Stimulus: four blocks with in_valid=out_ready=1 continuously.
  - Required response: results spaced exactly 9 cycles apart, all correct.
- Mid-RUN reset and parametrisation:
  - Stimulus: assert rst_n=0 at b=4.
  - Required response: all outputs are at reset values immediately; the next block is correct.
  - Repeat the first two scenarios at W=12, ROM_W=20 with x_k=-2048 and check out_data=-16384.

Source files
------------

// File: rtl/da_dct_engine.sv
// Bit-serial distributed-arithmetic inner product over eight signed samples, one DCT coefficient per block.
// Per bit slice, two 16-entry ROM words are summed and weighted by 2^b. The MSB slice is subtracted, which keeps two's-complement inputs exact.
module da_dct_engine #(
  parameter int W     = 8,
  parameter int ROM_W = 16,
  parameter int OUT_W = ROM_W + W + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*W-1:0]          x_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [3:0]              addr_a,
  output logic [3:0]              addr_b,
  input  logic signed [ROM_W-1:0] rom_a_data,
  input  logic signed [ROM_W-1:0] rom_b_data,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                  state;
  logic [CW-1:0]           b;
  logic [8*W-1:0]          smp;
  logic [8*W-1:0]          smp_sh;
  logic signed [OUT_W-1:0] acc;
  logic signed [ROM_W:0]   s_sum;
  logic signed [OUT_W-1:0] term;
  logic signed [OUT_W-1:0] next_acc;
  logic                    last;

  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);

  // Shifting the sample register right by b puts bit b of every sample at a fixed position.
  assign smp_sh = smp >> b;

  always_comb begin
    addr_a = '0;
    addr_b = '0;
    if (state == RUN) begin
      for (int k = 0; k < 4; k++) begin
        addr_a[k] = smp_sh[k*W];
        addr_b[k] = smp_sh[(k+4)*W];
      end
    end
  end

  assign s_sum    = {rom_a_data[ROM_W-1], rom_a_data} + {rom_b_data[ROM_W-1], rom_b_data};
  assign term     = {{(OUT_W-ROM_W-1){s_sum[ROM_W]}}, s_sum} <<< b;
  assign last     = (b == CW'(W - 1));
  assign next_acc = last ? (acc - term) : (acc + term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      b         <= '0;
      smp       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            smp   <= x_in;
            b     <= '0;
            acc   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (last) begin
            out_data  <= next_acc;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            acc <= next_acc;
            b   <= b + CW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              smp   <= x_in;
              b     <= '0;
              acc   <= '0;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_da_dct_engine.sv
// Directed bench for da_dct_engine: popcount ROMs (Y = sum of samples), weighted ROM, back-pressure, streaming, reset, W=12.
module tb_da_dct_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // W=8 instance
  logic [63:0]        x8;
  logic               iv8, ir8, ov8, ordy;
  logic [3:0]         aa8, ab8;
  logic signed [15:0] ra8, rb8;
  logic signed [24:0] od8;
  logic               rom_mode;

  // W=12 instance
  logic [95:0]        x12;
  logic               iv12, ir12, ov12;
  logic [3:0]         aa12, ab12;
  logic signed [19:0] ra12, rb12;
  logic signed [32:0] od12;

  da_dct_engine #(.W(8), .ROM_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .x_in(x8), .in_valid(iv8), .in_ready(ir8),
    .addr_a(aa8), .addr_b(ab8), .rom_a_data(ra8), .rom_b_data(rb8),
    .out_data(od8), .out_valid(ov8), .out_ready(ordy)
  );

  da_dct_engine #(.W(12), .ROM_W(20)) dut12 (
    .clk(clk), .rst_n(rst_n), .x_in(x12), .in_valid(iv12), .in_ready(ir12),
    .addr_a(aa12), .addr_b(ab12), .rom_a_data(ra12), .rom_b_data(rb12),
    .out_data(od12), .out_valid(ov12), .out_ready(ordy)
  );

  always_comb begin
    int t;
    t = 0;
    if (rom_mode) begin
      if (aa8[0]) t = t + 1000;
      if (aa8[1]) t = t - 2000;
      ra8 = 16'(t);
      rb8 = 16'sd0;
    end else begin
      ra8 = 16'($countones(aa8));
      rb8 = 16'($countones(ab8));
    end
    ra12 = 20'($countones(aa12));
    rb12 = 20'($countones(ab12));
  end

  logic   sel;
  logic   ov_m, ir_m;
  longint od_m;
  always_comb begin
    ov_m = sel ? ov12 : ov8;
    ir_m = sel ? ir12 : ir8;
    od_m = sel ? longint'(od12) : longint'(od8);
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [63:0] r;
    r[7:0]   = a0[7:0];  r[15:8]  = a1[7:0];
    r[23:16] = a2[7:0];  r[31:24] = a3[7:0];
    r[39:32] = a4[7:0];  r[47:40] = a5[7:0];
    r[55:48] = a6[7:0];  r[63:56] = a7[7:0];
    return r;
  endfunction

  function automatic logic [95:0] pk12(input int v);
    logic [95:0] r;
    for (int k = 0; k < 8; k++) r[k*12 +: 12] = v[11:0];
    return r;
  endfunction

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ov_m && n < 40);
  endtask

  // One block with out_ready=1: latency, result, single-cycle valid, return to IDLE.
  task automatic run_block(input logic [95:0] x, input int lat, input longint exp, input string tag);
    int n;
    if (sel) begin x12 = x; iv12 = 1'b1; end
    else begin x8 = x[63:0]; iv8 = 1'b1; end
    tick();
    iv8 = 1'b0; iv12 = 1'b0;
    chk({tag, "_run_in_ready"}, ir_m, 0);
    wait_valid(n);
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_data"}, od_m, exp);
    tick();
    chk({tag, "_valid_drop"}, ov_m, 0);
    chk({tag, "_idle_in_ready"}, ir_m, 1);
  endtask

  initial begin
    int n, t_prev;
    logic [63:0] blk [4];
    longint      sums [4];

    sel = 1'b0; rom_mode = 1'b0; ordy = 1'b1;
    iv8 = 1'b0; iv12 = 1'b0; x8 = '0; x12 = '0;
    #3;
    chk("rst_out_valid", ov8, 0);
    chk("rst_out_data", od8, 0);
    chk("rst_in_ready", ir8, 1);
    chk("rst_addr", {aa8, ab8}, 0);
    #9 rst_n = 1'b1;

    run_block(96'(pk8(1,1,1,1,1,1,1,1)), 8, 8, "basic");
    run_block(96'(pk8(-128,-128,-128,-128,-128,-128,-128,-128)), 8, -1024, "neg_ext");
    run_block(96'(pk8(127,-128,5,-7,0,1,-1,64)), 8, 61, "mixed");

    rom_mode = 1'b1;
    run_block(96'(pk8(-3,5,0,0,0,0,0,0)), 8, -13000, "weighted");
    rom_mode = 1'b0;

    // Back-pressure: second block waits in x_in with in_valid high throughout.
    ordy = 1'b0;
    x8 = pk8(1,2,3,4,5,6,7,8); iv8 = 1'b1;
    tick();
    x8 = pk8(-10,20,-30,40,-50,60,-70,80);
    wait_valid(n);
    chk("bp_latency", n, 8);
    chk("bp_first_data", od8, 36);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_data", od8, 36);
      chk("bp_hold_valid", ov8, 1);
      chk("bp_hold_in_ready", ir8, 0);
    end
    ordy = 1'b1;
    #1;
    chk("bp_release_in_ready", ir8, 1);
    tick();
    iv8 = 1'b0;
    chk("bp_accept_valid", ov8, 0);
    chk("bp_accept_in_ready", ir8, 0);
    wait_valid(n);
    chk("bp_second_latency", n, 8);
    chk("bp_second_data", od8, 40);
    tick();

    // Back-to-back stream of four blocks.
    blk[0] = pk8(10,10,10,10,10,10,10,10);           sums[0] = 80;
    blk[1] = pk8(-1,-1,-1,-1,-1,-1,-1,-1);           sums[1] = -8;
    blk[2] = pk8(100,-100,50,-50,127,-128,3,4);      sums[2] = 6;
    blk[3] = pk8(1,2,4,8,16,32,64,-128);             sums[3] = -1;
    x8 = blk[0]; iv8 = 1'b1;
    tick();
    x8 = blk[1];
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_valid(n);
      chk("b2b_data", od8, sums[i]);
      if (i > 0) chk("b2b_spacing", cyc - t_prev, 9);
      t_prev = cyc;
      tick();
      if (i + 2 < 4) x8 = blk[i+2];
      else iv8 = 1'b0;
    end
    chk("b2b_idle", ov8, 0);

    // Reset asserted while b=4 of a block in flight.
    x8 = pk8(-1,-1,-1,-1,-1,-1,-1,-1); iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_addr_live", {aa8, ab8}, 8'hFF);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ov8, 0);
    chk("mid_rst_data", od8, 0);
    chk("mid_rst_in_ready", ir8, 1);
    chk("mid_rst_addr", {aa8, ab8}, 0);
    #1 rst_n = 1'b1;
    wait_valid(n);
    chk("mid_no_partial", ov8, 0);
    run_block(96'(pk8(3,3,3,3,3,3,3,3)), 8, 24, "post_rst");

    // Wider configuration.
    sel = 1'b1;
    chk("w12_rst_data", od12, 0);
    run_block(pk12(1), 12, 8, "w12_basic");
    run_block(pk12(-2048), 12, -16384, "w12_neg_ext");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
